// File: rtl/flappy_pkg.sv
// Shared screen geometry, colour constants and renderer types for the flappy
// frame renderer and its pixel shader.
package flappy_pkg;

   localparam int SCREEN_W   = 160;
   localparam int SCREEN_H   = 120;
   localparam int BIRD_X     = 20;
   localparam int BIRD_SIZE  = 4;
   localparam int WALL_WIDTH = 10;
   localparam int GAP_HEIGHT = 40;

   localparam logic [2:0] BIRD_COLOUR       = 3'b010;
   localparam logic [2:0] WALL_COLOUR       = 3'b100;
   localparam logic [2:0] BACKGROUND_COLOUR = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } render_state_t;

   typedef struct packed {
      logic [7:0] bird_y;
      logic [7:0] wall_x;
      logic [7:0] gap_y;
   } snapshot_t;

endpackage

// File: rtl/flappy_frame_renderer_if.sv
// Pixel plot bus between the frame renderer and the VGA adapter write port.
interface flappy_frame_renderer_if;

   logic       plot_valid;
   logic       plot_ready;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;

   modport master (output plot_valid, x_out, y_out, colour_out, input plot_ready);
   modport slave  (input plot_valid, x_out, y_out, colour_out, output plot_ready);

endinterface

// File: rtl/flappy_pixel_shader.sv
// Combinational colour lookup for one pixel against a latched game snapshot.
module flappy_pixel_shader
   import flappy_pkg::*;
(
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  snapshot_t  snap,
   output logic [2:0] colour,
   output logic       bird_hit,
   output logic       wall_hit
);

   logic [8:0] x9;
   logic [8:0] y9;
   logic [8:0] bird_top;
   logic [8:0] wall_left;
   logic [8:0] gap_top;

   // Bounds are compared at 9 bits so edges near 255 never wrap into range
   assign x9        = {1'b0, x};
   assign y9        = {2'b00, y};
   assign bird_top  = {1'b0, snap.bird_y};
   assign wall_left = {1'b0, snap.wall_x};
   assign gap_top   = {1'b0, snap.gap_y};

   assign bird_hit = (x9 >= 9'(BIRD_X)) && (x9 < 9'(BIRD_X + BIRD_SIZE)) &&
                     (y9 >= bird_top) && (y9 < bird_top + 9'(BIRD_SIZE));

   assign wall_hit = (x9 >= wall_left) && (x9 < wall_left + 9'(WALL_WIDTH)) &&
                     ((y9 < gap_top) || (y9 >= gap_top + 9'(GAP_HEIGHT)));

   always_comb begin
      colour = BACKGROUND_COLOUR;
      if (bird_hit) begin
         colour = BIRD_COLOUR;
      end else if (wall_hit) begin
         colour = WALL_COLOUR;
      end
   end

endmodule

// File: rtl/flappy_frame_renderer.sv
// Raster-scans one latched game snapshot per frame_start and streams every
// pixel over a valid/ready plot bus, reporting frame completion and collision.
module flappy_frame_renderer
   import flappy_pkg::*;
(
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            frame_start,
   input  logic [7:0]                      bird_y,
   input  logic [7:0]                      wall_x,
   input  logic [7:0]                      gap_y,
   flappy_frame_renderer_if.master         plot,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            collision
);

   render_state_t state;
   render_state_t state_next;
   snapshot_t     snap;
   logic [7:0]    x_cnt;
   logic [6:0]    y_cnt;
   logic [2:0]    shade_colour;
   logic          bird_hit;
   logic          wall_hit;
   logic          accept;
   logic          last_col;
   logic          last_pixel;

   flappy_pixel_shader u_shader (
      .x        (x_cnt),
      .y        (y_cnt),
      .snap     (snap),
      .colour   (shade_colour),
      .bird_hit (bird_hit),
      .wall_hit (wall_hit)
   );

   assign accept     = (state == SCAN) && plot.plot_ready;
   assign last_col   = (x_cnt == 8'(SCREEN_W - 1));
   assign last_pixel = last_col && (y_cnt == 7'(SCREEN_H - 1));

   assign plot.x_out = x_cnt;
   assign plot.y_out = y_cnt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next      = state;
      plot.plot_valid = 1'b0;
      plot.colour_out = 3'b000;
      busy            = 1'b0;
      frame_done      = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            plot.plot_valid = 1'b1;
            plot.colour_out = shade_colour;
            busy            = 1'b1;
            if (accept && last_pixel) begin
               state_next = DONE;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Counters only move on an accepted pixel, which keeps the bus stable under backpressure
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x_cnt     <= 8'd0;
         y_cnt     <= 7'd0;
         snap      <= '0;
         collision <= 1'b0;
      end else if ((state == IDLE) && frame_start) begin
         snap.bird_y <= bird_y;
         snap.wall_x <= wall_x;
         snap.gap_y  <= gap_y;
         x_cnt       <= 8'd0;
         y_cnt       <= 7'd0;
         collision   <= 1'b0;
      end else if (accept) begin
         collision <= collision | (bird_hit & wall_hit);
         if (last_col) begin
            x_cnt <= 8'd0;
            y_cnt <= last_pixel ? 7'd0 : y_cnt + 7'd1;
         end else begin
            x_cnt <= x_cnt + 8'd1;
         end
      end
   end

endmodule
